// File: rtl/booth_radix4_multiplier.sv
// -----------------------------------------------------------------------------
// booth_radix4_multiplier
//
// Sequential radix-4 Booth multiplier. It handles signed (two's complement) or
// unsigned WIDTH-bit operands and produces a 2*WIDTH-bit product.
//
// Operation
//   - Both operands are extended to WIDTH+2 bits: sign-extended in signed mode,
//     zero-extended in unsigned mode.
//   - Extending to WIDTH+2 bits lets one radix-4 Booth datapath cover both
//     modes with the same iteration count, ITER = WIDTH/2 + 1.
//   - Each CALC cycle retires one Booth digit.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         request a multiplication (sampled only in IDLE)
//   signed_mode   1 = two's complement operands, 0 = unsigned (sampled with start)
//   multiplicand  operand M (sampled with start)
//   multiplier    operand Q (sampled with start)
//   busy          high while iterating (CALC)
//   done          one-cycle pulse; product valid
//   product       2*WIDTH-bit result, held until the next result is written
// -----------------------------------------------------------------------------
module booth_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = WIDTH + 4;
  localparam int ITER  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [EXT_W-1:0]        q_reg;
  logic                    q_m1;
  logic signed [EXT_W-1:0] m_reg;
  logic [CNT_W-1:0]        cnt;

  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic [EXT_W-1:0]        q_next;

  // Extend an operand to WIDTH+2 bits according to the requested mode.
  function automatic logic [EXT_W-1:0] extend_operand(input logic [WIDTH-1:0] v,
                                                      input logic            sgn);
    extend_operand = {{2{sgn & v[WIDTH-1]}}, v};
  endfunction

  // Booth digit selection from the triplet {Q1,Q0,Q-1}.
  // Returns 0, +/-M or +/-2M, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] booth_addend(input logic [2:0]              trip,
                                                           input logic signed [EXT_W-1:0] m);
    logic signed [ACC_W-1:0] m_ext;
    m_ext = {{2{m[EXT_W-1]}}, m};
    case (trip)
      3'b001, 3'b010: booth_addend = m_ext;
      3'b011:         booth_addend = m_ext <<< 1;
      3'b100:         booth_addend = -(m_ext <<< 1);
      3'b101, 3'b110: booth_addend = -m_ext;
      default:        booth_addend = '0;
    endcase
  endfunction

  // One iteration: add the selected multiple, then shift {A,Q,Q-1} right by 2.
  // Arithmetic shift is used so that A keeps its sign.
  always_comb begin
    acc_sum  = acc + booth_addend({q_reg[1:0], q_m1}, m_reg);
    acc_next = acc_sum >>> 2;
    q_next   = {acc_sum[1:0], q_reg[EXT_W-1:2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            m_reg <= extend_operand(multiplicand, signed_mode);
            q_reg <= extend_operand(multiplier, signed_mode);
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_W'(ITER);
          end
        end
        CALC: begin
          acc   <= acc_next;
          q_reg <= q_next;
          q_m1  <= q_reg[1];
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            // Low 2*WIDTH bits of the final {A,Q}.
            // Q supplies WIDTH+2 bits and A supplies the remaining WIDTH-2 bits.
            product <= {acc_next[WIDTH-3:0], q_next};
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_radix4_multiplier
//
// Scoreboard bench for booth_radix4_multiplier. It instantiates two DUTs:
//   - a WIDTH=8 instance, driven with directed vectors;
//   - a WIDTH=16 instance, driven with directed vectors plus random pairs
//     checked against a reference product.
//
// Drivers push the expected product and the expected done cycle into a queue.
// Per-instance monitors pop and compare on every done pulse.
// -----------------------------------------------------------------------------
module tb_booth_radix4_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, sm8;
  logic [7:0]  m8, q8;
  logic        busy8, done8;
  logic [15:0] p8;
  logic        start16, sm16;
  logic [15:0] m16, q16;
  logic        busy16, done16;
  logic [31:0] p16;

  booth_radix4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(p8)
  );

  booth_radix4_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .multiplicand(m16), .multiplier(q16),
    .busy(busy16), .done(done16), .product(p16)
  );

  typedef struct {
    logic [31:0] prod;
    int          at;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   run8   = 0;
  int   run16  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref16(input bit s, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      ref16 = sa * sb;
    end else begin
      ref16 = {16'h0, a} * {16'h0, b};
    end
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst)        run8 = 0;
    else if (busy8) run8++;
    if (done8) begin
      chk("busy8_with_done", 32'(busy8), 32'd0);
      if (sb8.size() == 0) begin
        chk("done8_unexpected", 32'(p8), 32'hFFFFFFFF);
      end else begin
        e = sb8.pop_front();
        chk("product8", 32'(p8), e.prod);
        chk("done8_cycle", 32'(cyc), 32'(e.at));
        chk("busy8_cycles", 32'(run8), 32'd5);
      end
      run8 = 0;
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst)         run16 = 0;
    else if (busy16) run16++;
    if (done16) begin
      chk("busy16_with_done", 32'(busy16), 32'd0);
      if (sb16.size() == 0) begin
        chk("done16_unexpected", p16, ~p16);
      end else begin
        e = sb16.pop_front();
        chk("product16", p16, e.prod);
        chk("done16_cycle", 32'(cyc), 32'(e.at));
        chk("busy16_cycles", 32'(run16), 32'd9);
      end
      run16 = 0;
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while ((busy8 || done8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle8_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle16();
    int n = 0;
    while ((busy16 || done16) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle16_timeout", 32'(n), 32'd0);
  endtask

  task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] req);
    wait_idle8();
    sm8    = s;
    m8     = a;
    q8     = b;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    sb8.push_back('{32'(req), cyc + 5});
  endtask

  task automatic issue16(input bit s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] req);
    wait_idle16();
    sm16    = s;
    m16     = a;
    q16     = b;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    sb16.push_back('{req, cyc + 9});
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    bit rs;

    rst     = 1'b0;
    start8  = 1'b0; sm8  = 1'b0; m8  = '0; q8  = '0;
    start16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0;

    // Reset asserted between clock edges: outputs must clear without a clock.
    #2 rst = 1'b1;
    #1;
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_product8", 32'(p8), 32'd0);
    chk("reset_product16", p16, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed 8-bit vectors.
    issue8(1'b1, 8'h80, 8'h80, 16'h4000);
    issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    issue8(1'b0, 8'h00, 8'hFF, 16'h0000);
    issue8(1'b1, 8'h07, 8'hFD, 16'hFFEB);
    issue8(1'b1, 8'hFF, 8'h7F, 16'hFF81);
    issue8(1'b1, 8'h7F, 8'h80, 16'hC080);
    issue8(1'b0, 8'h80, 8'h02, 16'h0100);
    issue8(1'b1, 8'hFB, 8'hFA, 16'h001E);
    issue8(1'b0, 8'hC8, 8'h64, 16'h4E20);
    issue8(1'b1, 8'hFF, 8'hFF, 16'h0001);
    issue8(1'b0, 8'hFF, 8'h01, 16'h00FF);

    // Start re-pulsed with new operands and toggled mode while iterating.
    issue8(1'b1, 8'h07, 8'hFD, 16'hFFEB);
    for (int i = 0; i < 3; i++) begin
      start8 = 1'b1;
      sm8    = ~sm8;
      m8     = 8'h55;
      q8     = 8'hAA;
      @(negedge clk);
    end
    start8 = 1'b0;

    // Start raised during DONE is ignored; it is taken in the following IDLE cycle.
    issue8(1'b0, 8'h03, 8'h05, 16'h000F);
    n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("done8_timeout", 32'(n), 32'd0);
    sm8    = 1'b0;
    m8     = 8'h0A;
    q8     = 8'h0B;
    start8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b0;
    sb8.push_back('{32'h0000006E, cyc + 5});

    // Reset in the third CALC cycle aborts the operation.
    wait_idle8();
    sm8    = 1'b0;
    m8     = 8'h09;
    q8     = 8'h09;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_product8", 32'(p8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue8(1'b0, 8'h0C, 8'h0C, 16'h0090);

    // 16-bit instance: directed corners, then random pairs against the reference.
    issue16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
    issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    issue16(1'b1, 16'h04D2, 16'hFFFF, 32'hFFFFFB2E);
    issue16(1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = i[0];
      issue16(rs, ra, rb, ref16(rs, ra, rb));
    end

    // Drain both scoreboards, then watch for stray done pulses.
    n = 0;
    while ((sb8.size() != 0 || sb16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sb16_drained", 32'(sb16.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 Port start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 Port signed_mode  input  1  operand interpretation, sampled with start: 1 = two's complement, 0 = unsigned.
REQ-006 Port multiplicand  input  WIDTH  operand M, sampled with start.
REQ-007 Port multiplier  input  WIDTH  operand Q, sampled with start.
REQ-008 Port busy  output  1  high while in CALC.
REQ-009 Port done  output  1  single-cycle pulse; product valid.
REQ-010 Port product  output  2*WIDTH  result; held from done until the next accepted start.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-012 IDLE with start=1 SHALL transition to CALC at the next edge.
REQ-013 The IDLE->CALC transition SHALL latch the operands, clear the accumulator A and Q-1, and load the iteration counter with ITER = WIDTH/2+1.
REQ-014 Operands SHALL be extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if signed_mode=0; iteration count is therefore identical for both modes.
REQ-015 A SHALL be WIDTH+4 bits signed so that +/-2M never overflows.
REQ-016 Each CALC cycle SHALL decode the triplet {Q1,Q0,Q-1}:
  - 000/111 -> +0
  - 001/010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101/110 -> -M
REQ-017 In the same CALC cycle, the selected operand SHALL be added to A, then {A,Q,Q-1} SHALL be arithmetic-shifted right by 2.
REQ-018 The same CALC cycle SHALL also decrement the counter.
REQ-019 When the counter equals 1 in CALC, the FSM SHALL go to DONE at the next edge; otherwise it SHALL stay in CALC.
REQ-020 DONE SHALL last exactly one cycle with done=1 and then return to IDLE unconditionally.
REQ-021 product SHALL be updated on entry to DONE with the low 2*WIDTH bits of the final {A,Q} concatenation.
REQ-022 Latency: start sampled at edge 0 -> busy high for cycles 1..ITER -> done high in cycle ITER+1 (WIDTH=8: done 6 cycles after the start edge).
REQ-023 start SHALL be ignored in CALC and DONE; operand or mode changes during CALC SHALL NOT affect the result.
REQ-024 A start presented in the DONE cycle SHALL be ignored; it is accepted only if it is still high in the following IDLE cycle.
REQ-025 Results SHALL be exact for all operand pairs, including the most-negative values and mixed signs in signed mode.
REQ-026 busy and done SHALL never be high simultaneously.
REQ-027 Outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Reset
REQ-028 rst=1 SHALL force state to IDLE immediately, irrespective of clk.
REQ-029 rst=1 SHALL clear busy=0, done=0, product=0, A, Q, Q-1, M and the counter.
REQ-030 rst asserted mid-CALC SHALL abort the operation: no done pulse and product=0.
REQ-031 After rst deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Verification
REQ-032 WIDTH=8, signed_mode=1, M=-128, Q=-128, start -> busy for 5 cycles, then done with product=16'h4000 (16384).
REQ-033 WIDTH=8, signed_mode=0, M=255, Q=255 -> product=16'hFE01 (65025); M=0, Q=255 -> product=16'h0000; same latency as REQ-032.
REQ-034 WIDTH=8, signed_mode=1, M=7, Q=-3 -> product=16'hFFEB (-21); M=-1, Q=127 -> product=16'hFF81.
REQ-035 Start with 7*-3, then re-pulse start with other operands and toggle signed_mode during CALC -> single done, product=16'hFFEB, no second operation launched.
REQ-036 Start, assert rst in the 3rd CALC cycle, release, then start with 12*12 -> no done before reset, product=0 after reset, then done after 5 busy cycles with product=16'h0090.
REQ-037 WIDTH=16 randomized: 1000 signed and unsigned pairs vs a reference model -> all products exact, done always 10 cycles after the start edge.
